interrupt_request_bank: RTL and testbench

INTERRUPT_REQUEST_BANK -- requirements
Module: interrupt_request_bank

---
 rtl/interrupt_request_bank.sv | 108 ++++++++++
 tb/tb_interrupt_request_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_request_bank.sv
// Interrupt request register bank: per-channel pin synchronisers, edge/level
// capture into IRR, sticky lost-request flags and a fixed-priority encoder.
module interrupt_request_bank #(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               write_initial_command_word_1_reset,
  input  logic [NUM_IRQ-1:0] level_triggered_config,
  input  logic               freeze,
  input  logic [NUM_IRQ-1:0] clear_interrupt_request,
  input  logic [NUM_IRQ-1:0] interrupt_request_pin,
  output logic [NUM_IRQ-1:0] interrupt_request_register,
  output logic [NUM_IRQ-1:0] lost_request,
  output logic               any_request,
  output logic [IDX_W-1:0]   highest_request_index
);

  logic [NUM_IRQ-1:0]     sync_reg [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] primed_reg;
  logic [NUM_IRQ-1:0]     arm_reg, arm_next;
  logic [NUM_IRQ-1:0]     irr_reg, irr_next;
  logic [NUM_IRQ-1:0]     lost_reg, lost_next;
  logic [NUM_IRQ-1:0]     sync;
  logic                   primed;

  // primed_reg marks when the final sync stage holds a real pin sample rather
  // than its reset value, so a pin already high at reset release never arms.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_reg[s] <= '0;
      end
      primed_reg <= '0;
    end else begin
      sync_reg[0]   <= interrupt_request_pin;
      primed_reg[0] <= 1'b1;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_reg[s]   <= sync_reg[s-1];
        primed_reg[s] <= primed_reg[s-1];
      end
    end
  end

  assign sync   = sync_reg[SYNC_STAGES-1];
  assign primed = primed_reg[SYNC_STAGES-1];

  always_comb begin
    arm_next  = arm_reg;
    irr_next  = irr_reg;
    lost_next = lost_reg;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (write_initial_command_word_1_reset || clear_interrupt_request[i]) begin
        arm_next[i]  = 1'b0;
        irr_next[i]  = 1'b0;
        lost_next[i] = 1'b0;
      end else if (freeze) begin
        if (primed && !sync[i]) begin
          arm_next[i] = 1'b1;
        end
      end else if (level_triggered_config[i]) begin
        // Arm tracks "pin currently low" so a later switch to edge mode
        // cannot fire on a pin that was already high.
        irr_next[i] = sync[i];
        arm_next[i] = primed & ~sync[i];
      end else if (!sync[i]) begin
        if (primed) begin
          arm_next[i] = 1'b1;
        end
      end else if (arm_reg[i]) begin
        arm_next[i] = 1'b0;
        if (irr_reg[i]) begin
          lost_next[i] = 1'b1;
        end else begin
          irr_next[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      arm_reg  <= '0;
      irr_reg  <= '0;
      lost_reg <= '0;
    end else begin
      arm_reg  <= arm_next;
      irr_reg  <= irr_next;
      lost_reg <= lost_next;
    end
  end

  always_comb begin
    highest_request_index = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irr_reg[i]) begin
        highest_request_index = IDX_W'(i);
      end
    end
  end

  assign interrupt_request_register = irr_reg;
  assign lost_request               = lost_reg;
  assign any_request                = |irr_reg;

endmodule

// File: tb/tb_interrupt_request_bank.sv
// Self-checking bench for interrupt_request_bank (NUM_IRQ=8, SYNC_STAGES=2):
// one table row per clock, expected state queued at drive and checked after the edge.
module tb_interrupt_request_bank;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       icw1;
  logic [7:0] cfg;
  logic       frz;
  logic [7:0] clr;
  logic [7:0] pin;
  logic [7:0] irr;
  logic [7:0] lost;
  logic       any;
  logic [2:0] idx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       icw1;
    logic [7:0] cfg;
    logic       frz;
    logic [7:0] clr;
    logic [7:0] pin;
    logic [7:0] irr;
    logic [7:0] lost;
  } vec_t;

  typedef struct {
    int         row;
    logic [7:0] irr;
    logic [7:0] lost;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  interrupt_request_bank dut (
    .clock                              (clock),
    .reset_n                            (reset_n),
    .write_initial_command_word_1_reset (icw1),
    .level_triggered_config             (cfg),
    .freeze                             (frz),
    .clear_interrupt_request            (clr),
    .interrupt_request_pin              (pin),
    .interrupt_request_register         (irr),
    .lost_request                       (lost),
    .any_request                        (any),
    .highest_request_index              (idx)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] exp_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  task automatic cmp(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %02h expected %02h", name, row, act, exp);
    end
  endtask

  task automatic add(input int n, input logic i1, input logic [7:0] c, input logic f,
                     input logic [7:0] cl, input logic [7:0] p,
                     input logic [7:0] ei, input logic [7:0] el);
    vec_t v;
    v.icw1 = i1; v.cfg = c; v.frz = f; v.clr = cl; v.pin = p; v.irr = ei; v.lost = el;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic step(input vec_t v, input int row);
    exp_t e;
    exp_t got;
    @(negedge clock);
    icw1 = v.icw1; cfg = v.cfg; frz = v.frz; clr = v.clr; pin = v.pin;
    e.row = row; e.irr = v.irr; e.lost = v.lost;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard row %0d: got empty queue expected entry", row);
    end else begin
      got = sb.pop_front();
      cmp("irr",   got.row, irr,  got.irr);
      cmp("lost",  got.row, lost, got.lost);
      cmp("any",   got.row, {7'd0, any}, {7'd0, |got.irr});
      cmp("index", got.row, {5'd0, idx}, {5'd0, exp_idx(got.irr)});
      $display("row %0d pin=%02h cfg=%02h frz=%0b clr=%02h icw1=%0b -> irr=%02h lost=%02h idx=%0d",
               got.row, v.pin, v.cfg, v.frz, v.clr, v.icw1, irr, lost, idx);
    end
  endtask

  initial begin
    vec_t v;
    int   row;

    // Edge capture latency on pin 3, clear while held high, re-arm.
    add(4, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(2, 0, 8'h00, 0, 8'h00, 8'h08, 8'h00, 8'h00);
    add(2, 0, 8'h00, 0, 8'h00, 8'h08, 8'h08, 8'h00);
    add(1, 0, 8'h00, 0, 8'h08, 8'h08, 8'h00, 8'h00);
    add(2, 0, 8'h00, 0, 8'h00, 8'h08, 8'h00, 8'h00);
    add(2, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(2, 0, 8'h00, 0, 8'h00, 8'h08, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 8'h00, 8'h08, 8'h08, 8'h00);
    add(1, 0, 8'h00, 0, 8'h08, 8'h08, 8'h00, 8'h00);
    // Lost request on pin 2, then simultaneous pins 0 and 6.
    add(3, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(2, 0, 8'h00, 0, 8'h00, 8'h04, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 8'h00, 8'h04, 8'h04, 8'h00);
    add(3, 0, 8'h00, 0, 8'h00, 8'h00, 8'h04, 8'h00);
    add(2, 0, 8'h00, 0, 8'h00, 8'h04, 8'h04, 8'h00);
    add(1, 0, 8'h00, 0, 8'h00, 8'h04, 8'h04, 8'h04);
    add(1, 0, 8'h00, 0, 8'h04, 8'h04, 8'h00, 8'h00);
    add(3, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(2, 0, 8'h00, 0, 8'h00, 8'h41, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 8'h00, 8'h41, 8'h41, 8'h00);
    add(1, 0, 8'h00, 0, 8'h01, 8'h41, 8'h40, 8'h00);
    add(1, 0, 8'h00, 0, 8'h40, 8'h00, 8'h00, 8'h00);
    // Level mode on pin 5 with a clear mid-pulse.
    add(2, 0, 8'h20, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(2, 0, 8'h20, 0, 8'h00, 8'h20, 8'h00, 8'h00);
    add(1, 0, 8'h20, 0, 8'h00, 8'h20, 8'h20, 8'h00);
    add(1, 0, 8'h20, 0, 8'h20, 8'h20, 8'h00, 8'h00);
    add(1, 0, 8'h20, 0, 8'h00, 8'h20, 8'h20, 8'h00);
    add(2, 0, 8'h20, 0, 8'h00, 8'h00, 8'h20, 8'h00);
    add(2, 0, 8'h20, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    // Freeze: pending edge captures on unfreeze; pin low before unfreeze does not.
    add(2, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(4, 0, 8'h00, 1, 8'h00, 8'h02, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 8'h00, 8'h02, 8'h02, 8'h00);
    add(1, 0, 8'h00, 0, 8'h02, 8'h00, 8'h00, 8'h00);
    add(2, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    add(3, 0, 8'h00, 1, 8'h00, 8'h02, 8'h00, 8'h00);
    add(3, 0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 8'h00);
    // ICW1 clears IRR and lost, syncs keep the high pin so no recapture.
    add(2, 0, 8'h00, 0, 8'h00, 8'h01, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h00);
    add(3, 0, 8'h00, 0, 8'h00, 8'h00, 8'h01, 8'h00);
    add(2, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h00);
    add(1, 0, 8'h00, 0, 8'h00, 8'h01, 8'h01, 8'h01);
    add(1, 1, 8'h00, 0, 8'h00, 8'h01, 8'h00, 8'h00);
    add(1, 0, 8'h00, 0, 8'h00, 8'h01, 8'h00, 8'h00);
    // All channels to level mode with every pin high: IRR fills to FF.
    add(2, 0, 8'hFF, 0, 8'h00, 8'hFF, 8'h01, 8'h00);
    add(1, 0, 8'hFF, 0, 8'h00, 8'hFF, 8'hFF, 8'h00);

    reset_n = 1'b0;
    icw1 = 1'b0; cfg = 8'h00; frz = 1'b0; clr = 8'h00; pin = 8'h00;
    repeat (2) @(negedge clock);
    cmp("reset_irr",  -1, irr,  8'h00);
    cmp("reset_lost", -1, lost, 8'h00);
    cmp("reset_idx",  -1, {5'd0, idx}, 8'h00);
    reset_n = 1'b1;

    row = 0;
    foreach (vecs[k]) begin
      step(vecs[k], row);
      row++;
    end

    // Asynchronous reset with IRR=FF: outputs drop without a clock edge.
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    cfg = 8'h00;
    #1;
    cmp("async_irr",  row, irr,  8'h00);
    cmp("async_lost", row, lost, 8'h00);
    cmp("async_any",  row, {7'd0, any}, 8'h00);
    cmp("async_idx",  row, {5'd0, idx}, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;

    // Pins high across release must not capture; a real low then high does.
    v.icw1 = 1'b0; v.cfg = 8'h00; v.frz = 1'b0; v.clr = 8'h00; v.lost = 8'h00;
    v.pin = 8'hFF; v.irr = 8'h00;
    for (int k = 0; k < 5; k++) begin step(v, row); row++; end
    v.pin = 8'h00;
    for (int k = 0; k < 3; k++) begin step(v, row); row++; end
    v.pin = 8'hFF;
    for (int k = 0; k < 2; k++) begin step(v, row); row++; end
    v.irr = 8'hFF;
    step(v, row); row++;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
